// File: rtl/hazard_ctrl_s3.sv
// Pipeline hazard controller: load-use stall, branch flush window, memory-busy freeze.
// Optional HAZARD_PERF_EN macro adds stall/flush performance counters.
module hazard_ctrl_s3 #(
    parameter int unsigned FLUSH_EXTRA = 0,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_en,
    output logic        id_ex_flush,
    output logic [1:0]  state_o,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StFlush   = 2'b01,
        StMemWait = 2'b10
    } state_e;

    localparam logic [3:0]  FlushExtraW = 4'(FLUSH_EXTRA);
    localparam logic [15:0] MemTimeoutW = 16'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    state_e      ret_state_q, ret_state_d;
    state_e      eff_state;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] busy_cnt_q, busy_cnt_d;
    logic        err_q, err_d;
    logic        load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // Leaving MEM_WAIT behaves exactly like the state that was interrupted.
    assign eff_state = (state_q == StMemWait) ? ret_state_q : state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StRun;
            ret_state_q <= StRun;
            flush_cnt_q <= '0;
            busy_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            flush_cnt_q <= flush_cnt_d;
            busy_cnt_q  <= busy_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_state_d = ret_state_q;
        flush_cnt_d = flush_cnt_q;
        busy_cnt_d  = busy_cnt_q;
        err_d       = err_q;
        if (mem_busy) begin
            if (state_q != StMemWait) begin
                ret_state_d = state_q;
                state_d     = StMemWait;
                busy_cnt_d  = 16'd1;
            end else if (busy_cnt_q != 16'hFFFF) begin
                busy_cnt_d = busy_cnt_q + 16'd1;
            end
            if (busy_cnt_d >= MemTimeoutW) begin
                err_d = 1'b1;
            end
        end else begin
            busy_cnt_d = '0;
            state_d    = eff_state;
            case (eff_state)
                StFlush: begin
                    if (flush_cnt_q <= 4'd1) begin
                        state_d     = StRun;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 4'd1;
                    end
                end
                default: begin
                    if (ex_branch_taken && (FlushExtraW != 4'd0)) begin
                        state_d     = StFlush;
                        flush_cnt_d = FlushExtraW;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        state_o     = eff_state;
        if (!rst_n) begin
            // Latches carry no reset of their own; flush them while reset is held.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_o     = StRun;
        end else if (mem_busy) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            state_o  = StMemWait;
        end else if ((eff_state == StFlush) || ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign err_timeout = err_q;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (!pc_en) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (id_ex_flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_s3.sv
// Bench for hazard_ctrl_s3: two instances (FLUSH_EXTRA=2/MEM_TIMEOUT=8 and 0/3) against
// a pending-flush / busy-run model, directed steps followed by random traffic.
module tb_hazard_ctrl_s3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_busy;

    logic       pc_en[2], if_id_en[2], if_id_flush[2], id_ex_en[2], id_ex_flush[2];
    logic       err_timeout[2];
    logic [1:0] state_o[2];
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall[2], perf_flush[2];
`endif

    hazard_ctrl_s3 #(.FLUSH_EXTRA(2), .MEM_TIMEOUT(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en[0]), .if_id_en(if_id_en[0]), .if_id_flush(if_id_flush[0]),
        .id_ex_en(id_ex_en[0]), .id_ex_flush(id_ex_flush[0]), .state_o(state_o[0]),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt(perf_stall[0]), .perf_flush_cnt(perf_flush[0]),
`endif
        .err_timeout(err_timeout[0])
    );

    hazard_ctrl_s3 #(.FLUSH_EXTRA(0), .MEM_TIMEOUT(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en[1]), .if_id_en(if_id_en[1]), .if_id_flush(if_id_flush[1]),
        .id_ex_en(id_ex_en[1]), .id_ex_flush(id_ex_flush[1]), .state_o(state_o[1]),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt(perf_stall[1]), .perf_flush_cnt(perf_flush[1]),
`endif
        .err_timeout(err_timeout[1])
    );

    int unsigned fe[2] = '{2, 0};
    int unsigned mt[2] = '{8, 3};

    // Model: pending extra flush cycles, length of the current busy run, sticky error.
    int          m_flush_left[2];
    int          m_busy_run[2];
    logic        m_err[2];
    logic [31:0] m_stall[2], m_flush[2];
    bit          m_valid = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic step(input logic rn, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic busy);
        logic       lu;
        logic [4:0] exp_ctl;
        logic [1:0] exp_st;
        @(negedge clk);
        rst_n = rn; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br; mem_busy = busy;
        #1;
        lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        for (int k = 0; k < 2; k++) begin
            // Vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush
            exp_st = 2'd0;
            if (!rn)                       exp_ctl = 5'b00101;
            else if (busy) begin           exp_ctl = 5'b00000; exp_st = 2'd2; end
            else if (m_flush_left[k] > 0) begin exp_ctl = 5'b11111; exp_st = 2'd1; end
            else if (br)                   exp_ctl = 5'b11111;
            else if (lu)                   exp_ctl = 5'b00011;
            else                           exp_ctl = 5'b11010;
            check("ctl", k, 32'({pc_en[k], if_id_en[k], if_id_flush[k], id_ex_en[k],
                                  id_ex_flush[k]}), 32'(exp_ctl));
            if (rn) check("state", k, 32'(state_o[k]), 32'(exp_st));
            if (m_valid) check("err_timeout", k, 32'(err_timeout[k]), 32'(m_err[k]));
`ifdef HAZARD_PERF_EN
            if (m_valid) begin
                check("perf_stall", k, perf_stall[k], m_stall[k]);
                check("perf_flush", k, perf_flush[k], m_flush[k]);
            end
`endif
            if (!rn) begin
                m_flush_left[k] = 0; m_busy_run[k] = 0; m_err[k] = 1'b0;
                m_stall[k] = '0; m_flush[k] = '0;
            end else begin
                if (!exp_ctl[4]) m_stall[k] = m_stall[k] + 32'd1;
                if (exp_ctl[0])  m_flush[k] = m_flush[k] + 32'd1;
                if (busy) begin
                    if (m_busy_run[k] < 65535) m_busy_run[k]++;
                    if (m_busy_run[k] >= int'(mt[k])) m_err[k] = 1'b1;
                end else begin
                    m_busy_run[k] = 0;
                    if (m_flush_left[k] > 0) m_flush_left[k]--;
                    else if (br)             m_flush_left[k] = int'(fe[k]);
                end
            end
        end
        if (!rn) m_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int burst = 0;
        logic bz;
        rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = '0; ex_mem_read = 0; ex_branch_taken = 0; mem_busy = 0;

        // Reset held three cycles, then release.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Load-use on rs2, bubble follows; ex_rd=0 never stalls.
        step(1, 0, 5, 0, 1, 5, 1, 0, 0);
        step(1, 0, 5, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 1, 0, 0);
        step(1, 7, 3, 1, 0, 7, 1, 0, 0);
        step(1, 7, 3, 1, 0, 9, 0, 0, 0);

        // Branch pulse, and branch colliding with load-use.
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        step(1, 4, 0, 1, 0, 4, 1, 1, 0);
        idle(3);

        // mem_busy while one flush cycle remains.
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Held branch across a busy stretch takes effect on release.
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);

        // Timeout: 10 busy cycles, flag stays set until reset.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Perf scenario: one load-use then one branch.
        step(1, 2, 0, 1, 0, 2, 1, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);

        for (int i = 0; i < 800; i++) begin
            if (burst > 0) begin
                bz = 1'b1; burst--;
            end else if ($urandom_range(0, 14) == 0) begin
                bz = 1'b1; burst = $urandom_range(0, 9);
            end else begin
                bz = 1'b0;
            end
            step(($urandom_range(0, 99) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), bz);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
